// File: rtl/keypad_scanner_pkg.sv
// ============================================================================
// keypad_scanner_pkg: FSM and scan-result encodings plus the Pmod KYPD key map
// Revision: 1.0
// ============================================================================
`default_nettype none

package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_t;

  // Physical (row, col) position to the hex legend printed on the key.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'h0;
      4'hD:    code = 4'hF;
      4'hE:    code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scanner_col_driver.sv
// ============================================================================
// keypad_scanner_col_driver: column strobe generator with per-column sample and
// end-of-scan strobes.  Revision: 1.0
// ============================================================================
`default_nettype none

module keypad_scanner_col_driver #(
  parameter int SCAN_DIV = 100_000
) (
  input  logic       clock,
  input  logic       resetn,
  output logic [3:0] col,
  output logic [1:0] col_idx,
  output logic       sample_en,
  output logic       scan_done
);

  localparam int             DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [1:0]       idx;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div <= '0;
      idx <= 2'd0;
    end else if (div == DIV_LAST) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Sampling on the last cycle of a column gives the rows time to settle.
  assign sample_en = (div == DIV_LAST);
  assign scan_done = sample_en && (idx == 2'd3);
  assign col       = ~(4'b0001 << idx);
  assign col_idx   = idx;

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// keypad_scanner: 4x4 hex keypad reader with per-scan debouncing, delivering a
// key code, press strobe, held level and release strobe.  Revision: 1.0
// ============================================================================
`default_nettype none

module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 100_000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_release
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0] col_idx;
  logic       sample_en;
  logic       scan_done;

  keypad_scanner_col_driver #(.SCAN_DIV(SCAN_DIV)) u_col_driver (
    .clock     (clock),
    .resetn    (resetn),
    .col       (col),
    .col_idx   (col_idx),
    .sample_en (sample_en),
    .scan_done (scan_done)
  );

  logic [3:0] row_meta;
  logic [3:0] rs;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      row_meta <= 4'hF;
      rs       <= 4'hF;
    end else begin
      row_meta <= row;
      rs       <= row_meta;
    end
  end

  // Accumulator: hit count saturates at 2 (MULTI); key holds the single hit.
  logic [1:0] acc_hits;
  logic [3:0] acc_key;
  logic [1:0] base_hits;
  logic [3:0] base_key;
  logic [1:0] new_hits;
  logic [3:0] new_key;
  logic [3:0] pressed;
  logic [2:0] col_cnt;
  logic [1:0] col_row;
  scan_t      scan_res;

  always_comb begin
    pressed   = ~rs;
    base_hits = (col_idx == 2'd0) ? 2'd0 : acc_hits;
    base_key  = (col_idx == 2'd0) ? 4'h0 : acc_key;
    col_cnt   = {2'b00, pressed[0]} + {2'b00, pressed[1]} +
                {2'b00, pressed[2]} + {2'b00, pressed[3]};
    col_row   = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (pressed[r]) col_row = 2'(r);
    end
    new_hits = base_hits;
    new_key  = base_key;
    if (col_cnt == 3'd1 && base_hits == 2'd0) begin
      new_hits = 2'd1;
      new_key  = key_map(col_row, col_idx);
    end else if (col_cnt != 3'd0) begin
      new_hits = 2'd2;
    end
    case (new_hits)
      2'd0:    scan_res = SCAN_NONE;
      2'd1:    scan_res = SCAN_SINGLE;
      default: scan_res = SCAN_MULTI;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc_hits <= 2'd0;
      acc_key  <= 4'h0;
    end else if (sample_en) begin
      acc_hits <= new_hits;
      acc_key  <= new_key;
    end
  end

  state_t           state, state_n;
  logic [3:0]       cand, cand_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]       code_n;
  logic             valid_n, held_n, release_n;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cand        <= 4'h0;
      cnt         <= '0;
      key_code    <= 4'h0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_n;
      cand        <= cand_n;
      cnt         <= cnt_n;
      key_code    <= code_n;
      key_valid   <= valid_n;
      key_held    <= held_n;
      key_release <= release_n;
    end
  end

  // The FSM only advances on the end-of-scan sample, using that sample's result.
  always_comb begin
    state_n   = state;
    cand_n    = cand;
    cnt_n     = cnt;
    code_n    = key_code;
    valid_n   = 1'b0;
    held_n    = key_held;
    release_n = 1'b0;
    cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    if (scan_done) begin
      case (state)
        IDLE: begin
          if (scan_res == SCAN_SINGLE) begin
            cand_n = new_key;
            cnt_n  = CNT_ONE;
            if (CNT_ONE == CNT_MAX) begin
              code_n  = new_key;
              valid_n = 1'b1;
              held_n  = 1'b1;
              state_n = PRESSED;
            end else begin
              state_n = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (scan_res == SCAN_SINGLE && new_key == cand) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              code_n  = cand;
              valid_n = 1'b1;
              held_n  = 1'b1;
              state_n = PRESSED;
            end
          end else if (scan_res == SCAN_SINGLE) begin
            cand_n = new_key;
            cnt_n  = CNT_ONE;
          end else begin
            state_n = IDLE;
          end
        end
        PRESSED: begin
          if (scan_res == SCAN_NONE) begin
            cnt_n = CNT_ONE;
            if (CNT_ONE == CNT_MAX) begin
              held_n    = 1'b0;
              release_n = 1'b1;
              state_n   = IDLE;
            end else begin
              state_n = RELEASE_DB;
            end
          end
        end
        RELEASE_DB: begin
          if (scan_res == SCAN_NONE) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              held_n    = 1'b0;
              release_n = 1'b1;
              state_n   = IDLE;
            end
          end else begin
            state_n = PRESSED;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// tb_keypad_scanner: directed bench with a keypad matrix model (SCAN_DIV=4,
// DEBOUNCE_SCANS=3).  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

  localparam int SCAN = 16;

  logic        clock = 1'b0;
  logic        resetn;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        key_release;
  logic [15:0] keys;

  int tests = 0;
  int fails = 0;
  int valid_cycles = 0;
  int release_cycles = 0;
  int both_cycles = 0;
  int col_bad = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .row         (row),
    .col         (col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .key_release (key_release)
  );

  always #5 clock = ~clock;

  // Matrix model: a pressed key shorts its row to its column when that column is low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(negedge clock) begin
    if (key_valid) valid_cycles++;
    if (key_release) release_cycles++;
    if (key_valid && key_release) both_cycles++;
    if (!$onehot(~col)) col_bad++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic align_scan();
    logic [3:0] p;
    bit found;
    found = 1'b0;
    p = col;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clock);
      if (p == 4'b0111 && col == 4'b1110) found = 1'b1;
      p = col;
    end
    tests++;
    assert (found) else begin
      fails++;
      $error("FAIL align: observed no scan start, expected one within 80 cycles");
    end
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] expcol;
    resetn = 1'b0;
    keys   = 16'h0;
    repeat (3) @(negedge clock);
    check("rst_col", 32'(col), 32'hE);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);
    check("rst_release", 32'(key_release), 32'h0);

    // 1: idle column scan
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expcol = ~(4'b0001 << k);
      check("col_seq", 32'(col), 32'(expcol));
      repeat (4) @(negedge clock);
    end
    check("col_wrap", 32'(col), 32'hE);
    repeat (4*SCAN) @(negedge clock);
    check("idle_valid", 32'(valid_cycles), 32'd0);
    check("idle_release", 32'(release_cycles), 32'd0);
    check("idle_held", 32'(key_held), 32'd0);

    // 2: press and release '6' (r1,c2)
    keys[6] = 1'b1;
    repeat (6*SCAN) @(negedge clock);
    check("k6_valid", 32'(valid_cycles), 32'd1);
    check("k6_code", 32'(key_code), 32'h6);
    check("k6_held", 32'(key_held), 32'd1);
    check("k6_no_rel", 32'(release_cycles), 32'd0);
    keys = 16'h0;
    repeat (6*SCAN) @(negedge clock);
    check("k6_release", 32'(release_cycles), 32'd1);
    check("k6_unheld", 32'(key_held), 32'd0);
    check("k6_code_kept", 32'(key_code), 32'h6);

    // 3: bounce '9' (r2,c2) one scan on, one scan off, then hold
    align_scan();
    for (int b = 0; b < 3; b++) begin
      keys[10] = 1'b1;
      repeat (SCAN) @(negedge clock);
      keys = 16'h0;
      repeat (SCAN) @(negedge clock);
    end
    check("k9_bounce", 32'(valid_cycles), 32'd1);
    keys[10] = 1'b1;
    repeat (2*SCAN + 8) @(negedge clock);
    check("k9_early", 32'(valid_cycles), 32'd1);
    repeat (SCAN) @(negedge clock);
    check("k9_valid", 32'(valid_cycles), 32'd2);
    check("k9_code", 32'(key_code), 32'h9);
    keys = 16'h0;
    repeat (6*SCAN) @(negedge clock);
    check("k9_release", 32'(release_cycles), 32'd2);

    // 4: 'A'+'5' together, then 'D' alone
    keys[3] = 1'b1;
    keys[5] = 1'b1;
    repeat (6*SCAN) @(negedge clock);
    check("multi_valid", 32'(valid_cycles), 32'd2);
    check("multi_held", 32'(key_held), 32'd0);
    keys = 16'h0;
    keys[15] = 1'b1;
    repeat (6*SCAN) @(negedge clock);
    check("kD_valid", 32'(valid_cycles), 32'd3);
    check("kD_code", 32'(key_code), 32'hD);
    keys = 16'h0;
    repeat (6*SCAN) @(negedge clock);
    check("kD_release", 32'(release_cycles), 32'd3);

    // 5: hold '0', add 'F', drop '0'
    keys[12] = 1'b1;
    repeat (6*SCAN) @(negedge clock);
    check("k0_valid", 32'(valid_cycles), 32'd4);
    check("k0_code", 32'(key_code), 32'h0);
    keys[13] = 1'b1;
    repeat (3*SCAN) @(negedge clock);
    keys[12] = 1'b0;
    repeat (6*SCAN) @(negedge clock);
    check("kF_no_valid", 32'(valid_cycles), 32'd4);
    check("kF_code", 32'(key_code), 32'h0);
    check("kF_held", 32'(key_held), 32'd1);
    check("kF_no_rel", 32'(release_cycles), 32'd3);
    keys = 16'h0;
    repeat (6*SCAN) @(negedge clock);
    check("kF_release", 32'(release_cycles), 32'd4);
    check("kF_unheld", 32'(key_held), 32'd0);

    // 6: reset during PRESS_DB with cnt=2 while 'B' (r1,c3) is held
    align_scan();
    keys[7] = 1'b1;
    repeat (2*SCAN + 4) @(negedge clock);
    resetn = 1'b0;
    #1;
    check("mid_rst_col", 32'(col), 32'hE);
    check("mid_rst_code", 32'(key_code), 32'h0);
    check("mid_rst_valid", 32'(key_valid), 32'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (2*SCAN + 8) @(negedge clock);
    check("kB_early", 32'(valid_cycles), 32'd4);
    repeat (SCAN) @(negedge clock);
    check("kB_valid", 32'(valid_cycles), 32'd5);
    check("kB_code", 32'(key_code), 32'hB);
    keys = 16'h0;
    repeat (6*SCAN) @(negedge clock);
    check("kB_release", 32'(release_cycles), 32'd5);

    check("never_both", 32'(both_cycles), 32'd0);
    check("col_onehot", 32'(col_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
